word_port_target: RTL and testbench
===================================

Name: word_port_target

Overview:
- Target-side responder on the Amiga local bus for a 16-bit (word) peripheral port.
- Answers 040-style cycles: TSn, A[1:0], SIZ, RnW. Cycles arrive already split and lane-steered by the CPU-side bus sizing machine, so word data always sits on the UU/UM lanes.
- Reports PORTSIZE=word, runs a 68k-style AS/UDS/LDS/DTACK handshake to the device, and terminates with TACKn, TBIn or TEAn.

Parameters:
- WAIT_STATES, 2: minimum clocks the strobes are held before DEV_DTACKn is sampled (range 0-15).
- TIMEOUT, 255: clocks from strobe assertion to bus-error termination (8-bit counter). Used only with the optional feature.

Ports:
- CLK40  in  1  local bus clock; all logic on the rising edge.
- RESET  in  1  asynchronous reset, active-high.
- TSn  in  1  transfer start from the sizing machine, low for 1 clock.
- SEL  in  1  address decode hit for this port; qualified with TSn.
- RnW  in  1  1=read, 0=write.
- SIZ  in  2  00=long, 01=byte, 10=word, 11=line.
- A  in  2  A[1:0] from the sizing machine.
- PORTSIZE  out  1  1=word port; driven during an owned cycle.
- TACKn  out  1  normal termination, low 1 clock.
- TEAn  out  1  error termination, low 1 clock.
- TBIn  out  1  burst inhibit, low with TACKn on line cycles.
- D_AMIGA_IN  in  16  UU:UM lanes from the local bus (writes).
- D_AMIGA_OUT  out  16  UU:UM read data.
- D_AMIGA_OE  out  1  drive D_AMIGA_OUT.
- DEV_ASn  out  1  device address strobe.
- DEV_UDSn  out  1  upper data strobe.
- DEV_LDSn  out  1  lower data strobe.
- DEV_RnW  out  1  device direction.
- DEV_DTACKn  in  1  device acknowledge; async, double-registered.
- DEV_D_IN  in  16  device read data.
- DEV_D_OUT  out  16  device write data.
- DEV_D_OE  out  1  drive DEV_D_OUT.

Behaviour:
- Reset (async): state IDLE. PORTSIZE=0, TACKn=1, TEAn=1, TBIn=1, D_AMIGA_OE=0, DEV_ASn=1, DEV_UDSn=1, DEV_LDSn=1, DEV_RnW=1, DEV_D_OE=0, D_AMIGA_OUT=0, counters=0.
- Reset asserted mid-cycle: the same values apply immediately; no termination is issued.
- Lane/strobe decode:
  - SIZ 00/10/11: UDS and LDS both asserted.
  - SIZ 01: A[0]=0 asserts UDS only; A[0]=1 asserts LDS only.
  - A[1] is ignored.
- IDLE:
  - On TSn=0 and SEL=1, capture RnW, SIZ, A[0]; set PORTSIZE=1; go to STROBE.
  - TSn=0 with SEL=0 is ignored.
- STROBE (1 clock):
  - DEV_ASn=0, the decoded strobes=0, DEV_RnW=captured RnW.
  - On writes, DEV_D_OUT=D_AMIGA_IN and DEV_D_OE=1.
  - Load the wait counter with WAIT_STATES; go to WAIT.
- WAIT:
  - Count down; once zero, sample the synchronised DTACKn.
  - DTACKn=0: latch DEV_D_IN into D_AMIGA_OUT on reads; go to TERM.
- TERM (exactly 1 clock):
  - TACKn=0.
  - TBIn=0 if the captured SIZ=11, so the CPU falls back to single transfers.
  - D_AMIGA_OE=1 on reads.
  - Go to RECOVER.
- RECOVER:
  - TACKn/TEAn/TBIn=1, D_AMIGA_OE=0, all strobes=1, DEV_D_OE=0, PORTSIZE=0.
  - Stay until the synchronised DTACKn=1, then go to IDLE.
- Minimum latency, TSn low to TACKn low, with WAIT_STATES=0 and DTACKn already low: 4 clocks (IDLE, STROBE, WAIT incl. 2-flop sync, TERM).
- A TSn arriving in any state other than IDLE is ignored.
- PORTSIZE is valid by the 2nd rising edge after TSn sampled low, before the sizing machine samples it.
- Exactly one of TACKn or TEAn is asserted per accepted cycle; never both.

Optional Feature:
- Macro WORD_PORT_TIMEOUT_EN.
- Defined:
  - An 8-bit counter starts at STROBE and increments in WAIT.
  - At TIMEOUT it goes to ERR: TEAn=0 for 1 clock, TACKn=1, no read data driven, then RECOVER.
  - In RECOVER the counter reloads; if DTACKn has not negated within TIMEOUT clocks, go to IDLE anyway.
- Undefined: WAIT and RECOVER wait indefinitely; TEAn is tied to 1.

Test Plan:
- Word read, SIZ=10, A=00, WAIT_STATES=2, DTACKn low 1 clk after strobe, DEV_D_IN=0xBEEF -> UDSn=LDSn=0; TACKn low 1 clk; D_AMIGA_OUT=0xBEEF with OE=1 in the same clock; PORTSIZE=1 from TS+2 until TERM.
- Byte write, SIZ=01, A=01, D_AMIGA_IN=0x12AB -> only DEV_LDSn=0, DEV_RnW=0, DEV_D_OUT=0x12AB with OE=1; TACKn low 1 clk; TBIn=1.
- Line read, SIZ=11 -> TACKn and TBIn low in the same single clock; the next TSn in IDLE starts a fresh cycle.
- Long transfer split by the sizing machine: two TSn pulses, A=00 then A=10, with RECOVER honoured between -> two separate device cycles, each with UDS+LDS, two TACKn pulses.
- WORD_PORT_TIMEOUT_EN with TIMEOUT=16, DTACKn held high -> TEAn low 1 clk at strobe+16; TACKn stays 1; strobes negate next clk; back to IDLE.
- RESET pulsed during WAIT -> all outputs return to reset values within the same clock; no TACKn/TEAn; a following TSn is served normally.

Source files
------------

// File: rtl/word_port_target_if.sv
// Local-bus side of the word port: 040-style cycle start from the sizing machine,
// port-size report and termination back to it, and the UU:UM data lanes.
interface word_port_target_if;
   logic        TSn;
   logic        SEL;
   logic        RnW;
   logic [1:0]  SIZ;
   logic [1:0]  A;
   logic        PORTSIZE;
   logic        TACKn;
   logic        TEAn;
   logic        TBIn;
   logic [15:0] D_AMIGA_IN;
   logic [15:0] D_AMIGA_OUT;
   logic        D_AMIGA_OE;

   modport master (
      output TSn, SEL, RnW, SIZ, A, D_AMIGA_IN,
      input  PORTSIZE, TACKn, TEAn, TBIn, D_AMIGA_OUT, D_AMIGA_OE
   );

   modport slave (
      input  TSn, SEL, RnW, SIZ, A, D_AMIGA_IN,
      output PORTSIZE, TACKn, TEAn, TBIn, D_AMIGA_OUT, D_AMIGA_OE
   );
endinterface

// File: rtl/word_port_target.sv
// Word-port target: turns an owned 040-style cycle into a 68k AS/UDS/LDS/DTACK cycle.
// Define WORD_PORT_TIMEOUT_EN to add bus-error termination when the device never acknowledges.
module word_port_target #(
   parameter int unsigned WAIT_STATES = 2,
   parameter int unsigned TIMEOUT     = 255
) (
   input  logic        CLK40,
   input  logic        RESET,
   word_port_target_if.slave bus,
   output logic        DEV_ASn,
   output logic        DEV_UDSn,
   output logic        DEV_LDSn,
   output logic        DEV_RnW,
   input  logic        DEV_DTACKn,
   input  logic [15:0] DEV_D_IN,
   output logic [15:0] DEV_D_OUT,
   output logic        DEV_D_OE
);

   if (WAIT_STATES > 15 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_params
      $error("word_port_target: WAIT_STATES must be 0-15 and TIMEOUT 1-255");
   end

   localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_STROBE,
      ST_WAIT,
      ST_TERM,
      ST_ERR,
      ST_RECOVER
   } state_t;

   state_t     state;
   logic [3:0] wait_cnt;
   logic       read_cyc;
   logic       line_cyc;
   logic       dtack_meta;
   logic       dtack_sync;
   logic       byte_cyc;
   logic       uds_hit;
   logic       lds_hit;
   logic       dtack_seen;
   logic       unused_a1;

   // A byte cycle picks one lane from A[0]; every wider size uses both lanes.
   assign byte_cyc   = (bus.SIZ == 2'b01);
   assign uds_hit    = !byte_cyc || !bus.A[0];
   assign lds_hit    = !byte_cyc ||  bus.A[0];
   assign dtack_seen = (wait_cnt == 4'd0) && !dtack_sync;
   assign unused_a1  = bus.A[1];

   always_ff @(posedge CLK40 or posedge RESET) begin
      if (RESET) begin
         dtack_meta <= 1'b1;
         dtack_sync <= 1'b1;
      end else begin
         dtack_meta <= DEV_DTACKn;
         dtack_sync <= dtack_meta;
      end
   end

`ifdef WORD_PORT_TIMEOUT_EN
   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);
   logic [7:0] to_cnt;
`else
   assign bus.TEAn = 1'b1;
`endif

   // All outputs are registered; strobes go low on the edge that accepts the cycle.
   always_ff @(posedge CLK40 or posedge RESET) begin
      if (RESET) begin
         state           <= ST_IDLE;
         wait_cnt        <= 4'd0;
         read_cyc        <= 1'b1;
         line_cyc        <= 1'b0;
         bus.PORTSIZE    <= 1'b0;
         bus.TACKn       <= 1'b1;
         bus.TBIn        <= 1'b1;
         bus.D_AMIGA_OE  <= 1'b0;
         bus.D_AMIGA_OUT <= 16'h0000;
         DEV_ASn         <= 1'b1;
         DEV_UDSn        <= 1'b1;
         DEV_LDSn        <= 1'b1;
         DEV_RnW         <= 1'b1;
         DEV_D_OUT       <= 16'h0000;
         DEV_D_OE        <= 1'b0;
`ifdef WORD_PORT_TIMEOUT_EN
         bus.TEAn        <= 1'b1;
         to_cnt          <= 8'd0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (!bus.TSn && bus.SEL) begin
                  read_cyc     <= bus.RnW;
                  line_cyc     <= (bus.SIZ == 2'b11);
                  bus.PORTSIZE <= 1'b1;
                  DEV_ASn      <= 1'b0;
                  DEV_UDSn     <= !uds_hit;
                  DEV_LDSn     <= !lds_hit;
                  DEV_RnW      <= bus.RnW;
                  if (!bus.RnW) begin
                     DEV_D_OUT <= bus.D_AMIGA_IN;
                     DEV_D_OE  <= 1'b1;
                  end
`ifdef WORD_PORT_TIMEOUT_EN
                  to_cnt       <= 8'd0;
`endif
                  state        <= ST_STROBE;
               end
            end

            ST_STROBE: begin
               wait_cnt <= WAIT_LOAD;
`ifdef WORD_PORT_TIMEOUT_EN
               to_cnt   <= to_cnt + 8'd1;
`endif
               state    <= ST_WAIT;
            end

            // A device acknowledge on the same edge as the timeout still wins.
            ST_WAIT: begin
               if (dtack_seen) begin
                  if (read_cyc) begin
                     bus.D_AMIGA_OUT <= DEV_D_IN;
                  end
                  bus.TACKn      <= 1'b0;
                  bus.TBIn       <= !line_cyc;
                  bus.D_AMIGA_OE <= read_cyc;
                  state          <= ST_TERM;
               end
`ifdef WORD_PORT_TIMEOUT_EN
               else if (to_cnt == TIMEOUT_LAST) begin
                  bus.TEAn <= 1'b0;
                  state    <= ST_ERR;
               end
`endif
               else begin
                  if (wait_cnt != 4'd0) begin
                     wait_cnt <= wait_cnt - 4'd1;
                  end
`ifdef WORD_PORT_TIMEOUT_EN
                  to_cnt <= to_cnt + 8'd1;
`endif
               end
            end

            ST_TERM, ST_ERR: begin
               bus.TACKn      <= 1'b1;
               bus.TBIn       <= 1'b1;
               bus.D_AMIGA_OE <= 1'b0;
               bus.PORTSIZE   <= 1'b0;
               DEV_ASn        <= 1'b1;
               DEV_UDSn       <= 1'b1;
               DEV_LDSn       <= 1'b1;
               DEV_RnW        <= 1'b1;
               DEV_D_OE       <= 1'b0;
`ifdef WORD_PORT_TIMEOUT_EN
               bus.TEAn       <= 1'b1;
               to_cnt         <= 8'd0;
`endif
               state          <= ST_RECOVER;
            end

            ST_RECOVER: begin
               if (dtack_sync) begin
                  state <= ST_IDLE;
               end
`ifdef WORD_PORT_TIMEOUT_EN
               else if (to_cnt == TIMEOUT_LAST) begin
                  state <= ST_IDLE;
               end else begin
                  to_cnt <= to_cnt + 8'd1;
               end
`endif
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_word_port_target.sv
// Randomised bench for word_port_target with a behavioural device that answers DTACKn
// a chosen number of clocks after seeing the address strobe.
module tb_word_port_target;

   localparam int W  = 2;
   localparam int TO = 16;

   logic        CLK40 = 1'b0;
   logic        RESET;
   logic        DEV_ASn, DEV_UDSn, DEV_LDSn, DEV_RnW, DEV_D_OE;
   logic        DEV_DTACKn = 1'b1;
   logic [15:0] DEV_D_IN, DEV_D_OUT;

   int checks = 0;
   int errors = 0;
   int dev_delay = 1;
   bit dev_enable = 1'b1;
   int dev_cnt = 0;

   word_port_target_if bus();

   word_port_target #(.WAIT_STATES(W), .TIMEOUT(TO)) dut (
      .CLK40      (CLK40),
      .RESET      (RESET),
      .bus        (bus),
      .DEV_ASn    (DEV_ASn),
      .DEV_UDSn   (DEV_UDSn),
      .DEV_LDSn   (DEV_LDSn),
      .DEV_RnW    (DEV_RnW),
      .DEV_DTACKn (DEV_DTACKn),
      .DEV_D_IN   (DEV_D_IN),
      .DEV_D_OUT  (DEV_D_OUT),
      .DEV_D_OE   (DEV_D_OE)
   );

   always #5 CLK40 = ~CLK40;

   // Device model: acknowledge dev_delay falling edges after AS goes low, release when AS rises.
   always @(negedge CLK40) begin
      if (RESET || DEV_ASn) begin
         dev_cnt    = 0;
         DEV_DTACKn = 1'b1;
      end else begin
         dev_cnt++;
         if (dev_enable && dev_cnt >= dev_delay) DEV_DTACKn = 1'b0;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int modelLatency(input int dly, input bit err);
      int strobe_hold, ack_ready;
      strobe_hold = 2 + W;
      ack_ready   = dly + 2;
      if (err) return TO;
      return (strobe_hold > ack_ready) ? strobe_hold : ack_ready;
   endfunction

   task automatic checkReset(input string tag);
      checkOutput(tag, {bus.PORTSIZE, bus.TACKn, bus.TEAn, bus.TBIn, bus.D_AMIGA_OE,
                        DEV_ASn, DEV_UDSn, DEV_LDSn, DEV_RnW, DEV_D_OE},
                  {1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0});
      checkOutput({tag, "_rdata"}, bus.D_AMIGA_OUT, 16'h0000);
   endtask

   task automatic applyStimulus(input bit rnw, input logic [1:0] siz, input logic [1:0] a,
                                input logic [15:0] wdata, input logic [15:0] rdata,
                                input int dly, input bit stray, input bit exp_err);
      int  k, exp_k, noise;
      bit  done, exp_uds, exp_lds;
      exp_uds    = (siz != 2'b01) || (a[0] == 1'b0);
      exp_lds    = (siz != 2'b01) || (a[0] == 1'b1);
      exp_k      = modelLatency(dly, exp_err) + 1;
      dev_delay  = dly;
      dev_enable = !exp_err;
      @(negedge CLK40);
      bus.TSn = 1'b0; bus.SEL = 1'b1; bus.RnW = rnw; bus.SIZ = siz; bus.A = a;
      bus.D_AMIGA_IN = wdata; DEV_D_IN = rdata;
      k = 0; done = 1'b0;
      while (!done && k < 60) begin
         @(negedge CLK40);
         k++;
         bus.TSn = !(stray && k == 3);
         if (bus.TACKn == 1'b0 || bus.TEAn == 1'b0) begin
            done = 1'b1;
         end else begin
            if (k >= 2) checkOutput("portsize_hold", bus.PORTSIZE, 1'b1);
            if (k == 2) begin
               checkOutput("strobes", {DEV_ASn, DEV_UDSn, DEV_LDSn, DEV_RnW},
                           {1'b0, !exp_uds, !exp_lds, rnw});
               checkOutput("dev_d_oe", DEV_D_OE, !rnw);
               if (!rnw) checkOutput("dev_d_out", DEV_D_OUT, wdata);
            end
         end
      end
      checkOutput("term_seen", done, 1'b1);
      checkOutput("term_latency", k, exp_k);
      checkOutput("tackn", bus.TACKn, exp_err);
      checkOutput("tean", bus.TEAn, !exp_err);
      checkOutput("tbin", bus.TBIn, exp_err || (siz != 2'b11));
      checkOutput("amiga_oe", bus.D_AMIGA_OE, rnw && !exp_err);
      checkOutput("portsize_term", bus.PORTSIZE, 1'b1);
      if (rnw && !exp_err) checkOutput("read_data", bus.D_AMIGA_OUT, rdata);
      @(negedge CLK40);
      checkOutput("release", {bus.TACKn, bus.TEAn, bus.TBIn, bus.D_AMIGA_OE, DEV_ASn,
                              DEV_UDSn, DEV_LDSn, DEV_D_OE, bus.PORTSIZE},
                  {1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
      noise = 0;
      repeat (6) begin
         @(negedge CLK40);
         if (bus.TACKn == 1'b0 || bus.TEAn == 1'b0 || DEV_ASn == 1'b0) noise++;
      end
      checkOutput("after_quiet", noise, 0);
   endtask

   task automatic selMissIgnored();
      int noise = 0;
      @(negedge CLK40);
      bus.TSn = 1'b0; bus.SEL = 1'b0; bus.RnW = 1'b1; bus.SIZ = 2'b10; bus.A = 2'b00;
      @(negedge CLK40);
      bus.TSn = 1'b1;
      repeat (8) begin
         @(negedge CLK40);
         if (bus.TACKn == 1'b0 || DEV_ASn == 1'b0 || bus.PORTSIZE == 1'b1) noise++;
      end
      checkOutput("sel_miss", noise, 0);
   endtask

   task automatic resetDuringWait();
      int noise = 0;
      dev_delay = 6; dev_enable = 1'b1;
      @(negedge CLK40);
      bus.TSn = 1'b0; bus.SEL = 1'b1; bus.RnW = 1'b1; bus.SIZ = 2'b10; bus.A = 2'b00;
      DEV_D_IN = 16'h5A5A;
      @(negedge CLK40);
      bus.TSn = 1'b1;
      repeat (2) @(negedge CLK40);
      checkOutput("pre_reset_as", DEV_ASn, 1'b0);
      RESET = 1'b1;
      #1;
      checkReset("mid_reset");
      repeat (3) begin
         @(negedge CLK40);
         if (bus.TACKn == 1'b0 || bus.TEAn == 1'b0) noise++;
      end
      RESET = 1'b0;
      repeat (6) begin
         @(negedge CLK40);
         if (bus.TACKn == 1'b0 || bus.TEAn == 1'b0 || DEV_ASn == 1'b0) noise++;
      end
      checkOutput("reset_quiet", noise, 0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      RESET = 1'b1;
      bus.TSn = 1'b1; bus.SEL = 1'b0; bus.RnW = 1'b1; bus.SIZ = 2'b00; bus.A = 2'b00;
      bus.D_AMIGA_IN = 16'h0000; DEV_D_IN = 16'h0000;
      repeat (3) @(negedge CLK40);
      checkReset("reset");
      RESET = 1'b0;
      repeat (3) @(negedge CLK40);

      applyStimulus(1'b1, 2'b10, 2'b00, 16'h0000, 16'hBEEF, 1, 1'b0, 1'b0);
      applyStimulus(1'b0, 2'b01, 2'b01, 16'h12AB, 16'h0000, 2, 1'b0, 1'b0);
      applyStimulus(1'b0, 2'b01, 2'b00, 16'hCD34, 16'h0000, 1, 1'b0, 1'b0);
      applyStimulus(1'b1, 2'b11, 2'b00, 16'h0000, 16'hC0DE, 3, 1'b0, 1'b0);
      applyStimulus(1'b1, 2'b10, 2'b00, 16'h0000, 16'h1234, 1, 1'b0, 1'b0);
      applyStimulus(1'b0, 2'b00, 2'b00, 16'hA5A5, 16'h0000, 1, 1'b0, 1'b0);
      applyStimulus(1'b0, 2'b00, 2'b10, 16'h5A5A, 16'h0000, 4, 1'b0, 1'b0);
      selMissIgnored();
      applyStimulus(1'b1, 2'b10, 2'b00, 16'h0000, 16'h7777, 5, 1'b1, 1'b0);
`ifdef WORD_PORT_TIMEOUT_EN
      applyStimulus(1'b1, 2'b10, 2'b00, 16'h0000, 16'hDEAD, 1, 1'b0, 1'b1);
`endif
      resetDuringWait();
      applyStimulus(1'b1, 2'b10, 2'b00, 16'h0000, 16'h4321, 1, 1'b0, 1'b0);

      for (int i = 0; i < 40; i++) begin
         applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                       2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom),
                       int'($urandom_range(1, 6)), ($urandom_range(0, 3) == 0), 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
